uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have no parameters; 8N1 framing and 16x oversampling are fixed.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 baud_tick  input  1  one-clk enable pulse at 16x the bit rate (307.2 kHz for 19200 baud); the same tick that drives the transmitter.
REQ-005 rx  input  1  asynchronous serial line; idle high, LSB first.
REQ-006 data  output  8  last correctly framed byte; held until the next valid frame.
REQ-007 valid  output  1  one-clk pulse; data updated in the same cycle.
REQ-008 frame_err  output  1  one-clk pulse on a bad stop bit.
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer, giving rx_s; all other logic SHALL use only rx_s.
REQ-011 The FSM SHALL have states IDLE, START, DATA and STOP, and SHALL advance only on clocks where baud_tick=1.
REQ-012 A 4-bit tick counter cnt SHALL clear on every state entry and on every bit boundary; otherwise it SHALL increment once per baud_tick and wrap 15->0.
REQ-013 The bit value SHALL be the 2-of-3 majority of rx_s sampled on the ticks where the new cnt equals 7, 8 and 9; the decision is made on the cnt=9 tick.
REQ-014 An armed flag SHALL set on any tick with rx_s=1 and clear on entry to START.
REQ-015 IDLE->START SHALL occur on a tick with rx_s=0 and armed=1, with cnt<-0.
REQ-016 In START, a majority of 1 SHALL be a false start: return to IDLE with no output pulse.
REQ-017 In START, a majority of 0 SHALL cause the move to DATA on the tick where cnt wraps 15->0.
REQ-018 In DATA, each majority decision SHALL shift into an 8-bit shift register from the MSB side, so that bit 0 arrives first.
REQ-019 A 3-bit bit index SHALL increment at each bit boundary; after the 8th bit boundary the FSM SHALL enter STOP.
REQ-020 In STOP, at the decision tick the FSM SHALL return to IDLE immediately, without waiting for the end of the stop bit.
REQ-021 At the STOP decision, a majority of 1 SHALL load data from the shift register and pulse valid on the next clk edge.
REQ-022 At the STOP decision, a majority of 0 SHALL pulse frame_err on the next clk edge and leave data unchanged.
REQ-023 After a frame error, armed is clear, so a held-low (break) line SHALL NOT start a new frame until rx_s has been high on at least one tick.
REQ-024 valid and frame_err SHALL never be high in the same cycle, and each SHALL be high for exactly one clk per frame.
REQ-025 Latency from the STOP-decision baud_tick clock to the valid pulse SHALL be 1 clk.
REQ-026 The path from a line edge to rx_s SHALL add 2 clk.
REQ-027 Back-to-back frames with zero idle time between them SHALL be received without loss.

Reset
REQ-028 While rst=1 the block SHALL drive state=IDLE, cnt=0, bit index=0, shift register=0x00, data=0x00, valid=0, frame_err=0, busy=0 and armed=0.
REQ-029 The synchronizer flops SHALL reset to 1.
REQ-030 Reset mid-frame SHALL discard the partial byte with no pulse; reception SHALL resume only after rx_s has been high on at least one tick.

Verification
REQ-031 Frame 0xA5 at 16 ticks/bit -> exactly one valid pulse, data=0xA5, frame_err stays 0, busy drops at the STOP decision.
REQ-032 rx low for 4 ticks, then high -> false start, no valid or frame_err pulse, FSM back in IDLE.
REQ-033 Frame 0x3C followed by a frame whose stop bit is 0 -> one frame_err pulse, data stays 0x3C, and no new frame starts until rx returns high.
REQ-034 Single-tick low glitch at cnt=8 inside a 1 data bit of 0xFF -> majority rejects it, data=0xFF.
REQ-035 Back-to-back 0x00 then 0xFF with no idle, plus loopback from the team's transmitter for 256 random bytes -> every byte matches, one valid each, no frame_err.
REQ-036 rst asserted at bit 4 of a frame -> all outputs return to reset values the next clk; the following clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   8N1 serial receiver with 16x oversampling. The line is synchronized,
//   then each bit is decided by a 2-of-3 majority vote around mid-bit.
//   The FSM only moves on baud_tick clocks.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   baud_tick  one-clk enable at 16x the bit rate
//   rx         asynchronous serial input, idle high, LSB first
//   data       last correctly framed byte, held until the next good frame
//   valid      one-clk pulse, data updated in the same cycle
//   frame_err  one-clk pulse when the stop bit is sampled low
//   busy       high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_receiver (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       rx_meta_q, rx_s_q;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       armed_q, armed_d;
    logic       samp7_q, samp7_d;
    logic       samp8_q, samp8_d;
    logic [3:0] cnt_inc;
    logic       maj;

    // Value cnt takes on this tick; sampling points are defined on it.
    assign cnt_inc = cnt_q + 4'd1;

    // Majority of the two stored samples and the live sample; only
    // meaningful on the tick where cnt_inc == 9.
    assign maj = (samp7_q & samp8_q) | (samp7_q & rx_s_q) | (samp8_q & rx_s_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        armed_d   = armed_q;
        samp7_d   = samp7_q;
        samp8_d   = samp8_q;

        if (baud_tick) begin
            cnt_d = cnt_inc;
            if (cnt_inc == 4'd7) samp7_d = rx_s_q;
            if (cnt_inc == 4'd8) samp8_d = rx_s_q;
            // Any high sample re-arms start detection.
            if (rx_s_q) armed_d = 1'b1;

            case (state_q)
                IDLE: begin
                    if (!rx_s_q && armed_q) begin
                        state_d   = START;
                        cnt_d     = 4'd0;
                        bit_idx_d = 3'd0;
                        armed_d   = 1'b0;
                    end
                end
                START: begin
                    if (cnt_inc == 4'd9 && maj) begin
                        // Start bit did not hold low: false start.
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else if (cnt_q == 4'd15) begin
                        state_d = DATA;
                        cnt_d   = 4'd0;
                    end
                end
                DATA: begin
                    if (cnt_inc == 4'd9) shift_d = {maj, shift_q[7:1]};
                    if (cnt_q == 4'd15) begin
                        cnt_d     = 4'd0;
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_d = STOP;
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a following start edge
                    // with zero idle time is not missed.
                    if (cnt_inc == 4'd9) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                        if (maj) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d  = 1'b1;
                            // A held-low break must not restart reception
                            // until the line has been seen high again.
                            armed_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            armed_q   <= 1'b0;
            samp7_q   <= 1'b1;
            samp8_q   <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            armed_q   <= armed_d;
            samp7_q   <= samp7_d;
            samp8_q   <= samp8_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//   Drives the serial line one baud tick at a time (the bench acts as the
//   transmitter), collects received bytes and error pulses in a monitor,
//   and compares against the byte stream the bench itself sent.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, busy;

    int checks = 0;
    int passed = 0;
    int gap = 2;          // idle clocks between baud ticks

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int ferr_cnt = 0;
    int overlap  = 0;
    int bad_lat  = 0;
    int bad_busy = 0;

    uart_receiver dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Monitor: sample just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (valid) begin
                got_q.push_back(data);
                if (busy) bad_busy++;
                if (!baud_tick) bad_lat++;
            end
            if (frame_err) begin
                ferr_cnt++;
                if (!baud_tick) bad_lat++;
            end
            if (valid && frame_err) overlap++;
        end
    end

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        ferr_cnt = 0;
        overlap  = 0;
        bad_lat  = 0;
        bad_busy = 0;
    endtask

    // One baud tick with the line at level v.
    task automatic line_tick(input logic v);
        @(negedge clk);
        rx        = v;
        baud_tick = 1'b1;
        if (gap > 0) begin
            @(negedge clk);
            baud_tick = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic line_hold(input logic v, input int n);
        repeat (n) line_tick(v);
    endtask

    // 8N1 frame, 16 ticks per bit; optional one-tick inversion at tick 8
    // of data bit glitch_bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int glitch_bit);
        line_hold(1'b0, 16);
        for (int i = 0; i < 8; i++)
            for (int t = 0; t < 16; t++)
                line_tick((i == glitch_bit && t == 8) ? ~b[i] : b[i]);
        line_hold(stop_v, 16);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (data !== 8'h00) $display("FAIL reset_data: got %0h expected 00", data); else passed++;
        checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else passed++;
        checks++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", frame_err); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        clear_obs();
        line_hold(1'b1, 20);
        send_frame(8'hA5, 1'b1, -1);
        line_hold(1'b1, 4);
        checks++; if (got_q.size() !== 1) $display("FAIL a5_count: got %0d expected 1", got_q.size()); else passed++;
        checks++; if (got_q.size() < 1 || got_q[0] !== 8'hA5) $display("FAIL a5_pulse_data: got %0h expected a5", got_q.size() ? got_q[0] : 8'hxx); else passed++;
        checks++; if (data !== 8'hA5) $display("FAIL a5_data_held: got %0h expected a5", data); else passed++;
        checks++; if (ferr_cnt !== 0) $display("FAIL a5_ferr: got %0d expected 0", ferr_cnt); else passed++;
        checks++; if (bad_lat !== 0) $display("FAIL a5_latency: got %0d late pulses expected 0", bad_lat); else passed++;
        checks++; if (bad_busy !== 0) $display("FAIL a5_busy_drop: got %0d pulses with busy expected 0", bad_busy); else passed++;
    endtask

    task automatic test_false_start();
        clear_obs();
        line_hold(1'b1, 20);
        line_hold(1'b0, 4);
        checks++; if (busy !== 1'b1) $display("FAIL fs_busy_start: got %b expected 1", busy); else passed++;
        line_hold(1'b1, 30);
        checks++; if (busy !== 1'b0) $display("FAIL fs_back_idle: got %b expected 0", busy); else passed++;
        checks++; if (got_q.size() !== 0 || ferr_cnt !== 0)
            $display("FAIL fs_pulses: got %0d valid %0d ferr expected 0 0", got_q.size(), ferr_cnt); else passed++;
    endtask

    task automatic test_frame_error();
        clear_obs();
        line_hold(1'b1, 20);
        send_frame(8'h3C, 1'b1, -1);
        send_frame(8'hC3, 1'b0, -1);
        line_hold(1'b0, 40);
        checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h3C)
            $display("FAIL fe_good_byte: got %0d bytes first %0h expected 1 byte 3c", got_q.size(), got_q.size() ? got_q[0] : 8'hxx); else passed++;
        checks++; if (ferr_cnt !== 1) $display("FAIL fe_ferr_count: got %0d expected 1", ferr_cnt); else passed++;
        checks++; if (data !== 8'h3C) $display("FAIL fe_data_kept: got %0h expected 3c", data); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL fe_break_idle: got %b expected 0", busy); else passed++;
        checks++; if (overlap !== 0) $display("FAIL fe_overlap: got %0d expected 0", overlap); else passed++;
        line_hold(1'b1, 20);
        send_frame(8'h96, 1'b1, -1);
        line_hold(1'b1, 4);
        checks++; if (got_q.size() !== 2 || got_q[1] !== 8'h96)
            $display("FAIL fe_resume: got %0d bytes last %0h expected 2 bytes 96", got_q.size(), got_q.size() ? got_q[got_q.size()-1] : 8'hxx); else passed++;
    endtask

    task automatic test_glitch();
        clear_obs();
        line_hold(1'b1, 10);
        send_frame(8'hFF, 1'b1, 3);
        line_hold(1'b1, 4);
        checks++; if (got_q.size() !== 1 || got_q[0] !== 8'hFF)
            $display("FAIL glitch_data: got %0d bytes first %0h expected 1 byte ff", got_q.size(), got_q.size() ? got_q[0] : 8'hxx); else passed++;
        checks++; if (ferr_cnt !== 0) $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        clear_obs();
        line_hold(1'b1, 10);
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        line_hold(1'b1, 4);
        checks++; if (got_q.size() !== 2) $display("FAIL b2b_count: got %0d expected 2", got_q.size()); else passed++;
        checks++; if (got_q.size() < 2 || got_q[0] !== 8'h00 || got_q[1] !== 8'hFF)
            $display("FAIL b2b_bytes: got %0h %0h expected 00 ff", got_q.size() > 0 ? got_q[0] : 8'hxx, got_q.size() > 1 ? got_q[1] : 8'hxx); else passed++;
        checks++; if (ferr_cnt !== 0) $display("FAIL b2b_ferr: got %0d expected 0", ferr_cnt); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h5A;
        clear_obs();
        line_hold(1'b1, 10);
        line_hold(1'b0, 16);
        for (int i = 0; i < 4; i++) line_hold(b[i], 16);
        line_hold(b[4], 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (data !== 8'h00) $display("FAIL mid_rst_data: got %0h expected 00", data); else passed++;
        checks++; if (busy !== 1'b0 || valid !== 1'b0 || frame_err !== 1'b0)
            $display("FAIL mid_rst_ctrl: got busy %b valid %b ferr %b expected 0 0 0", busy, valid, frame_err); else passed++;
        rx  = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        line_hold(1'b0, 30);
        checks++; if (busy !== 1'b0) $display("FAIL mid_rst_unarmed: got %b expected 0", busy); else passed++;
        line_hold(1'b1, 20);
        send_frame(b, 1'b1, -1);
        line_hold(1'b1, 4);
        checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h5A)
            $display("FAIL mid_rst_next: got %0d bytes first %0h expected 1 byte 5a", got_q.size(), got_q.size() ? got_q[0] : 8'hxx); else passed++;
        checks++; if (ferr_cnt !== 0) $display("FAIL mid_rst_ferr: got %0d expected 0", ferr_cnt); else passed++;
    endtask

    task automatic test_loopback();
        logic [7:0] b;
        int errs;
        clear_obs();
        gap = 0;
        line_hold(1'b1, 10);
        for (int n = 0; n < 256; n++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, -1);
            if ($urandom_range(0, 1) == 1) line_hold(1'b1, $urandom_range(1, 20));
        end
        line_hold(1'b1, 8);
        @(negedge clk);
        baud_tick = 1'b0;
        gap = 2;
        checks++; if (got_q.size() !== 256) $display("FAIL loop_count: got %0d expected 256", got_q.size()); else passed++;
        errs = 0;
        for (int n = 0; n < 256 && n < got_q.size(); n++) begin
            checks++;
            if (got_q[n] !== exp_q[n]) begin
                if (errs < 8) $display("FAIL loop_byte[%0d]: got %0h expected %0h", n, got_q[n], exp_q[n]);
                errs++;
            end else passed++;
        end
        checks++; if (ferr_cnt !== 0) $display("FAIL loop_ferr: got %0d expected 0", ferr_cnt); else passed++;
        checks++; if (overlap !== 0 || bad_busy !== 0)
            $display("FAIL loop_pulse_rules: got overlap %0d busy %0d expected 0 0", overlap, bad_busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_false_start();
        test_frame_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
